// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive control slice.
package uart_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    AB_ARM    = 2'd1,
    AB_MEAS   = 2'd2,
    AB_SETTLE = 2'd3
  } state_t;

  localparam logic [15:0] DEFAULT_PRESCALE = 16'd868;
  localparam int          ERR_CNT_W        = 8;

endpackage

// File: rtl/uart_err_counter.sv
// Rising-edge detector on a sticky core error flag feeding a saturating event counter.
module uart_err_counter
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flag,
  input  logic                 core_rst,
  input  logic                 clear,
  output logic                 hit,
  output logic [ERR_CNT_W-1:0] count
);

  logic hist;

  // History is held low while the core is in reset so a re-armed core counts again.
  assign hit = flag & ~hist & ~core_rst;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist  <= 1'b0;
      count <= '0;
    end else begin
      hist <= core_rst ? 1'b0 : flag;
      if (clear)
        count <= '0;
      else if (hit && (count != '1))
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer around the UART receive core: prescale/reset ownership, 0x55 autobaud,
// FIFO drain into a valid/ready holding register, and error counters with interrupt.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int MIN_PRESCALE = 16,
  parameter int SETTLE_BITS  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           cfg_prescale,
  input  logic                  cfg_prescale_we,
  input  logic                  ab_start,
  input  logic                  flush,
  input  logic [1:0]            irq_en,
  input  logic                  err_clear,
  input  logic                  cnt_clear,
  input  logic                  rxd,
  output logic [15:0]           prescale,
  output logic                  core_rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ready,
  output logic                  rx_ack,
  input  logic                  overrun_error,
  input  logic                  framing_error,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  ab_busy,
  output logic                  ab_done,
  output logic                  ab_fail,
  output logic [ERR_CNT_W-1:0]  ovr_count,
  output logic [ERR_CNT_W-1:0]  frm_count,
  output logic                  irq
);

  localparam int BIT_W = $clog2(SETTLE_BITS + 1);

  state_t             state;
  logic               rxd_p0, rxd_p1;
  logic               line;
  logic [15:0]        cnt;
  logic [15:0]        measured;
  logic [15:0]        tmr;
  logic [BIT_W-1:0]   bits;
  logic               seen_high;
  logic               ab_ok;
  logic               ack_q;
  logic               err_pend;
  logic               ovr_hit, frm_hit;

  assign line     = rxd_p1;
  assign measured = cnt + 16'd1;
  assign ab_busy  = (state != RUN);

  // Pop only when the holding register can take the byte and the FIFO flags have had a cycle to update.
  assign rx_ack = (state == RUN) && rx_ready && (!m_valid || m_ready) && !ack_q && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      prescale  <= DEFAULT_PRESCALE;
      core_rst  <= 1'b1;
      ab_done   <= 1'b0;
      ab_fail   <= 1'b0;
      cnt       <= '0;
      tmr       <= '0;
      bits      <= '0;
      seen_high <= 1'b0;
      ab_ok     <= 1'b0;
    end else begin
      ab_done <= 1'b0;
      ab_fail <= 1'b0;
      case (state)
        RUN: begin
          core_rst <= flush | ab_start;
          if (ab_start) begin
            state     <= AB_ARM;
            seen_high <= 1'b0;
          end else if (cfg_prescale_we) begin
            prescale <= cfg_prescale;
          end
        end
        AB_ARM: begin
          core_rst <= 1'b1;
          if (line) begin
            seen_high <= 1'b1;
          end else if (seen_high) begin
            cnt   <= '0;
            state <= AB_MEAS;
          end
        end
        AB_MEAS: begin
          core_rst <= 1'b1;
          if (cnt == 16'hFFFF) begin
            ab_fail <= 1'b1;
            ab_ok   <= 1'b0;
            tmr     <= prescale - 16'd1;
            bits    <= '0;
            state   <= AB_SETTLE;
          end else if (!line) begin
            cnt <= cnt + 16'd1;
          end else if (measured < 16'(MIN_PRESCALE)) begin
            // Too short to be a real start bit: treat as a glitch and re-arm.
            ab_fail   <= 1'b1;
            seen_high <= 1'b1;
            state     <= AB_ARM;
          end else begin
            prescale <= measured;
            ab_ok    <= 1'b1;
            tmr      <= measured - 16'd1;
            bits     <= '0;
            state    <= AB_SETTLE;
          end
        end
        AB_SETTLE: begin
          core_rst <= 1'b1;
          if (!line) begin
            tmr  <= prescale - 16'd1;
            bits <= '0;
          end else if (tmr != 16'd0) begin
            tmr <= tmr - 16'd1;
          end else if (bits == BIT_W'(SETTLE_BITS - 1)) begin
            core_rst <= 1'b0;
            ab_done  <= ab_ok;
            state    <= RUN;
          end else begin
            bits <= bits + 1'b1;
            tmr  <= prescale - 16'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_p0   <= 1'b1;
      rxd_p1   <= 1'b1;
      ack_q    <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      err_pend <= 1'b0;
      irq      <= 1'b0;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
      ack_q  <= rx_ack;
      if (flush && (state == RUN)) begin
        m_valid <= 1'b0;
      end else if (rx_ack) begin
        m_data  <= rx_data;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (ovr_hit || frm_hit)
        err_pend <= 1'b1;
      else if (err_clear)
        err_pend <= 1'b0;
      irq <= (m_valid & irq_en[0]) | (err_pend & irq_en[1]);
    end
  end

  uart_err_counter u_ovr_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .flag     (overrun_error),
    .core_rst (core_rst),
    .clear    (cnt_clear),
    .hit      (ovr_hit),
    .count    (ovr_count)
  );

  uart_err_counter u_frm_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .flag     (framing_error),
    .core_rst (core_rst),
    .clear    (cnt_clear),
    .hit      (frm_hit),
    .count    (frm_count)
  );

endmodule
